// File: rtl/eoz_frame_sched.sv
// Round-robin front end for a shared serial even-ones/even-zeros checker.
// Optional EOZ_STATS_EN adds saturating frame/even-frame counters.
module eoz_frame_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    localparam int LW   = $clog2(WIDTH + 1),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*LW-1:0]    req_len,
    output logic [NREQ-1:0]       req_ready,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic                  busy,
    output logic                  res_valid,
    output logic [IW-1:0]         res_id,
    output logic                  res_ones_even,
    output logic                  res_zeros_even,
    output logic                  res_even,
`ifdef EOZ_STATS_EN
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_even,
`endif
    output logic [1:0]            dbg_state
);

    // Handshake: a frame moves on the posedge where req_valid[i] & req_ready[i];
    // req_ready is one-hot, only in IDLE, and does not depend on busy logic elsewhere.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_shreg;
    logic [LW-1:0]    r_count;
    logic [IW-1:0]    r_cur_id;
    logic [IW-1:0]    r_last_grant;
    logic             r_ones_par;
    logic             r_zeros_par;
    logic             r_ser_bit;
    logic             r_ser_valid;
    logic             r_res_valid;
    logic [IW-1:0]    r_res_id;
    logic             r_res_ones_even;
    logic             r_res_zeros_even;
    logic             r_res_even;

    logic             w_grant_any;
    logic [IW-1:0]    w_grant_id;
    logic [NREQ-1:0]  w_grant_oh;
    logic [WIDTH-1:0] w_acc_data;
    logic [LW-1:0]    w_acc_len_raw;
    logic [LW-1:0]    w_acc_len;
    logic             w_ones_fin;
    logic             w_zeros_fin;

    // Search starts just after the last served requester, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_grant_oh  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_grant_any && req_valid[idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = IW'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_grant_oh[i] = w_grant_any && (w_grant_id == IW'(i));
        end
    end

    assign w_acc_data    = req_data[int'(w_grant_id)*WIDTH +: WIDTH];
    assign w_acc_len_raw = req_len[int'(w_grant_id)*LW +: LW];
    assign w_acc_len     = (w_acc_len_raw > LW'(WIDTH)) ? LW'(WIDTH) : w_acc_len_raw;
    assign w_ones_fin    = r_ones_par ^ r_shreg[0];
    assign w_zeros_fin   = r_zeros_par ^ ~r_shreg[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant_oh;
                if (w_grant_any) begin
                    w_next = (w_acc_len == '0) ? ST_REPORT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == LW'(1)) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Serial outputs are loaded one cycle ahead so ser_bit is a plain register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg          <= '0;
            r_count          <= '0;
            r_cur_id         <= '0;
            r_last_grant     <= IW'(NREQ - 1);
            r_ones_par       <= 1'b0;
            r_zeros_par      <= 1'b0;
            r_ser_bit        <= 1'b0;
            r_ser_valid      <= 1'b0;
            r_res_valid      <= 1'b0;
            r_res_id         <= '0;
            r_res_ones_even  <= 1'b0;
            r_res_zeros_even <= 1'b0;
            r_res_even       <= 1'b0;
        end else begin
            r_ser_valid <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_shreg     <= w_acc_data;
                        r_count     <= w_acc_len;
                        r_cur_id    <= w_grant_id;
                        r_ones_par  <= 1'b0;
                        r_zeros_par <= 1'b0;
                        if (w_acc_len == '0) begin
                            r_res_valid      <= 1'b1;
                            r_res_id         <= w_grant_id;
                            r_res_ones_even  <= 1'b1;
                            r_res_zeros_even <= 1'b1;
                            r_res_even       <= 1'b1;
                        end else begin
                            r_ser_valid <= 1'b1;
                            r_ser_bit   <= w_acc_data[0];
                        end
                    end
                end
                ST_SHIFT: begin
                    r_ones_par  <= w_ones_fin;
                    r_zeros_par <= w_zeros_fin;
                    r_shreg     <= r_shreg >> 1;
                    r_count     <= r_count - LW'(1);
                    if (r_count == LW'(1)) begin
                        r_res_valid      <= 1'b1;
                        r_res_id         <= r_cur_id;
                        r_res_ones_even  <= ~w_ones_fin;
                        r_res_zeros_even <= ~w_zeros_fin;
                        r_res_even       <= ~w_ones_fin & ~w_zeros_fin;
                    end else begin
                        r_ser_valid <= 1'b1;
                        r_ser_bit   <= r_shreg[1];
                    end
                end
                ST_REPORT: r_last_grant <= r_cur_id;
                default: ;
            endcase
        end
    end

`ifdef EOZ_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_even;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_frames <= '0;
            r_stat_even   <= '0;
        end else if (r_res_valid) begin
            if (r_stat_frames != 16'hFFFF) begin
                r_stat_frames <= r_stat_frames + 16'd1;
            end
            if (r_res_even && (r_stat_even != 16'hFFFF)) begin
                r_stat_even <= r_stat_even + 16'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_even   = r_stat_even;
`endif

    assign ser_bit        = r_ser_bit;
    assign ser_valid      = r_ser_valid;
    assign res_valid      = r_res_valid;
    assign res_id         = r_res_id;
    assign res_ones_even  = r_res_ones_even;
    assign res_zeros_even = r_res_zeros_even;
    assign res_even       = r_res_even;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_eoz_frame_sched.sv
// Bench for eoz_frame_sched: per-cycle frame-level model plus directed literal checks.
module tb_eoz_frame_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int LW    = 4;
  localparam int IW    = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*LW-1:0]    req_len;
  logic [NREQ-1:0]       req_ready;
  logic                  ser_bit, ser_valid, busy, res_valid;
  logic [IW-1:0]         res_id;
  logic                  res_ones_even, res_zeros_even, res_even;
  logic [1:0]            dbg_state;
`ifdef EOZ_STATS_EN
  logic [15:0]           stat_frames, stat_even;
`endif

  eoz_frame_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_len(req_len), .req_ready(req_ready), .ser_bit(ser_bit),
    .ser_valid(ser_valid), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_ones_even(res_ones_even), .res_zeros_even(res_zeros_even),
    .res_even(res_even),
`ifdef EOZ_STATS_EN
    .stat_frames(stat_frames), .stat_even(stat_even),
`endif
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int ones_of(input logic [WIDTH-1:0] d, input int len);
    int n = 0;
    for (int i = 0; i < len; i++) n += int'(d[i]);
    return n;
  endfunction

  // frame-level model: where are we relative to the last accept
  bit              m_init = 0;
  bit              m_active = 0;
  int              m_n, m_len, m_id, m_rl;
  int              m_last = NREQ - 1;
  logic [WIDTH-1:0] m_data;
  int              m_frames = 0, m_even = 0;
  int              pick, e_ones;
  logic [NREQ-1:0] e_ready;
  bit              e_sv, e_rv;

  always @(negedge clk) begin
    if (m_init) begin
      e_ready = '0;
      if (!m_active) begin
        pick = rr_pick(req_valid, m_last);
        if (pick >= 0) e_ready[pick] = 1'b1;
      end
      e_sv = m_active && (m_n >= 1) && (m_n <= m_len);
      e_rv = m_active && (m_n == m_len + 1);
      check("req_ready", int'(req_ready), int'(e_ready));
      check("busy", int'(busy), int'(m_active));
      check("ser_valid", int'(ser_valid), int'(e_sv));
      check("res_valid", int'(res_valid), int'(e_rv));
      if (e_sv && ser_valid) check("ser_bit", int'(ser_bit), int'(m_data[m_n-1]));
      if (e_rv && res_valid) begin
        e_ones = ones_of(m_data, m_len);
        check("res_id", int'(res_id), m_id);
        check("res_ones_even", int'(res_ones_even), int'(e_ones % 2 == 0));
        check("res_zeros_even", int'(res_zeros_even), int'((m_len - e_ones) % 2 == 0));
        check("res_even", int'(res_even), int'(e_ones % 2 == 0 && (m_len - e_ones) % 2 == 0));
      end
`ifdef EOZ_STATS_EN
      check("stat_frames", int'(stat_frames), m_frames);
      check("stat_even", int'(stat_even), m_even);
`endif
    end
    // advance model across the coming posedge
    if (reset == 1'b0) begin
      m_init = 1; m_active = 0; m_last = NREQ - 1; m_frames = 0; m_even = 0;
    end else if (m_init) begin
      if (m_active) begin
        if (m_n == m_len + 1) begin
          e_ones = ones_of(m_data, m_len);
          m_frames++;
          if (e_ones % 2 == 0 && (m_len - e_ones) % 2 == 0) m_even++;
          m_active = 0;
        end else begin
          m_n++;
        end
      end else begin
        pick = rr_pick(req_valid, m_last);
        if (pick >= 0) begin
          m_active = 1; m_n = 1; m_id = pick; m_last = pick;
          m_data = req_data[pick*WIDTH +: WIDTH];
          m_rl = int'(req_len[pick*LW +: LW]);
          m_len = (m_rl > WIDTH) ? WIDTH : m_rl;
        end
      end
    end
  end

  // driver: offer one frame, wait for accept and verdict, capture the stream
  task automatic run_frame(input int id, input logic [7:0] data, input int len,
                           output int lat, output logic [7:0] bits, output int nbits,
                           output logic [3:0] res);
    int c0 = 0;
    bit got = 0;
    req_data[id*WIDTH +: WIDTH] = data;
    req_len[id*LW +: LW] = LW'(len);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; c0 = cyc; end
    end
    check("accept_seen", int'(got), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    bits = '0; nbits = 0; lat = -1; res = '0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ser_valid) begin
        if (nbits < 8) bits[nbits] = ser_bit;
        nbits++;
      end
      if (res_valid) begin
        got = 1; lat = cyc - c0;
        res = {res_id, res_ones_even, res_zeros_even, res_even};
      end
    end
    check("result_seen", int'(got), 1);
  endtask

  int lat, nbits, n, grant, nb;
  logic [7:0] bits;
  logic [3:0] res;
  bit got;

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_ser_valid", int'(ser_valid), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_ready", int'(req_ready), 0);
    @(posedge clk); #1 reset = 1'b1;

    run_frame(0, 8'b0000_0011, 8, lat, bits, nbits, res);
    check("f1_lat", lat, 9); check("f1_bits", int'(bits), 8'h03);
    check("f1_nbits", nbits, 8); check("f1_res", int'(res), 4'b0111);

    run_frame(0, 8'h01, 8, lat, bits, nbits, res);
    check("f2_lat", lat, 9); check("f2_bits", int'(bits), 8'h01);
    check("f2_res", int'(res), 4'b0000);

    run_frame(0, 8'hFF, 15, lat, bits, nbits, res);
    check("clamp_lat", lat, 9); check("clamp_nbits", nbits, 8);
    check("clamp_res", int'(res), 4'b0111);

    run_frame(1, 8'b0000_0101, 3, lat, bits, nbits, res);
    check("f3_lat", lat, 4); check("f3_bits", int'(bits), 8'h05);
    check("f3_nbits", nbits, 3); check("f3_res", int'(res), 4'b1100);

    // both requesters held: grants must alternate starting at 0
    req_data = {8'h3C, 8'hA5}; req_len = {4'd2, 4'd2}; req_valid = 2'b11;
    exp_q = {8'd0, 8'd1, 8'd0, 8'd1};
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        grant = req_ready[1] ? 1 : 0;
        check("rr_order", grant, int'(exp_q.pop_front()));
        n++;
      end
    end
    check("rr_count", n, 4);
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(negedge clk);

    run_frame(1, 8'hFF, 0, lat, bits, nbits, res);
    check("len0_lat", lat, 1); check("len0_nbits", nbits, 0);
    check("len0_res", int'(res), 4'b1111);

    // req1 raised and withdrawn while req0's frame is shifting
    req_data[7:0] = 8'h5A; req_len[3:0] = 4'd8; req_valid = 2'b01; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    check("drop_accept", int'(got), 1);
    @(posedge clk); #1 req_valid = 2'b10;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    repeat (12) @(negedge clk);
    check("drop_idle", int'(busy), 0);

    // reset during the 4th shifted bit
    req_data[7:0] = 8'($urandom_range(0, 255)); req_len[3:0] = 4'd8;
    req_valid = 2'b01; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    check("mid_accept", int'(got), 1);
    @(posedge clk); #1 req_valid = '0;
    nb = 1;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(posedge clk); #1;
      if (ser_valid) nb++;
    end
    check("mid_bits", nb, 4);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mid_ser_valid", int'(ser_valid), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_res_valid", int'(res_valid), 0);
`ifdef EOZ_STATS_EN
    check("mid_stat_frames", int'(stat_frames), 0);
    check("mid_stat_even", int'(stat_even), 0);
`endif
    @(posedge clk); #1;
    req_data = {8'h0F, 8'h33}; req_len = {4'd4, 4'd4}; req_valid = 2'b11;
    @(negedge clk);
    check("mid_rr_first", int'(req_ready), 1);
    @(posedge clk); #1 req_valid = '0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eoz_frame_sched.md
Name: eoz_frame_sched

Overview:
Round-robin scheduler that shares one serial even-ones/even-zeros checker between NREQ requesters. It accepts a parallel word plus length from the granted requester and shifts the word out LSB-first as a bit stream. It tracks ones/zeros parity on the fly and reports a per-frame verdict tagged with the requester id. It sits between parallel producers and the serial bit-stream parity logic.

Parameters:
WIDTH, 8, max frame length in bits; data word width per requester
NREQ, 2, number of requesters (>=2)
LW (localparam), $clog2(WIDTH+1), width of one length field
IW (localparam), $clog2(NREQ), width of requester id

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
req_valid  input  NREQ  per-requester frame available
req_data  input  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
req_len  input  NREQ*LW  requester i bit count at [i*LW +: LW]; legal 0..WIDTH
req_ready  output  NREQ  one-hot accept pulse; frame taken when valid&ready
ser_bit  output  1  current serial bit
ser_valid  output  1  ser_bit meaningful this cycle
busy  output  1  state != IDLE
res_valid  output  1  one-cycle verdict pulse
res_id  output  IW  requester of reported frame
res_ones_even  output  1  count of ones in frame is even
res_zeros_even  output  1  count of zeros in frame is even
res_even  output  1  res_ones_even & res_zeros_even

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; the registered outputs ser_bit, ser_valid, res_valid, res_id, res_ones_even, res_zeros_even and res_even all 0; parity regs 0; rr pointer such that requester 0 has highest priority next. busy=0 and req_ready=0 follow from state=IDLE with no grant.
- States: IDLE, SHIFT, REPORT.
- IDLE: req_ready is combinational. It is high only for the requester chosen round-robin among req_valid, searching from last_grant+1 upward with wrap. Accept at posedge T: latch data into shreg, len into bit counter, id into cur_id; clear ones_par/zeros_par. Go to SHIFT if len!=0, else REPORT. No valid -> stay IDLE.
- len>WIDTH is clamped to WIDTH.
- SHIFT: ser_valid=1, ser_bit=shreg[0]. Each cycle: ones_par^=bit, zeros_par^=~bit, shreg>>=1, count-=1. Leaving at count==1 -> REPORT.
- REPORT: res_valid=1 for exactly one cycle with res_id=cur_id, res_ones_even=~ones_par, res_zeros_even=~zeros_par, res_even=AND. Update last_grant=cur_id. Next state IDLE.
- Latency: accept at T -> bits on cycles T+1..T+len -> res_valid at T+len+1. len=0 -> res_valid at T+1 with res_even=1 (0 ones, 0 zeros, both even). Next accept no earlier than T+len+2.
- req_ready is never asserted outside IDLE. Requester data may change freely after accept.
- Reset mid-frame: frame is aborted, no res_valid, ser_valid=0 next cycle, rr restarts at requester 0.
- req_valid dropped before grant: no accept; no frame is lost or duplicated.
- Outputs other than req_ready/busy are registered.

Optional Feature:
EOZ_STATS_EN: when defined, adds outputs stat_frames[15:0] (frames reported) and stat_even[15:0] (frames with res_even=1). Both increment on res_valid, saturate at 16'hFFFF, and clear on reset. When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Frame req0 data=8'b0000_0011 len=8 after reset -> ser_bit 1,1,0,0,0,0,0,0; res_valid at accept+9; res_id=0, ones_even=1, zeros_even=1, res_even=1.
- Frame data=8'h01 len=8 -> ones=1, zeros=7 -> ones_even=0, zeros_even=0, res_even=0.
- Frame data=8'b0000_0101 len=3 -> ser_bit 1,0,1; ones_even=1, zeros_even=0, res_even=0; res_valid at accept+4.
- Both req_valid held high, 4 frames -> grant order 0,1,0,1; req_ready one-hot, only in IDLE; res_id matches.
- len=0 on req1 -> ser_valid never high; res_valid at accept+1 with res_even=1, res_id=1.
- reset=0 during the 4th shifted bit -> next cycle ser_valid=0, busy=0, no res_valid; both valid afterwards -> req0 granted first; with EOZ_STATS_EN, counters read 0.
